// File: rtl/bus_bridge_pkg.sv
// rtl/bus_bridge_pkg.sv - FSM state codes, TX frame field offsets and frame packing helper
package bus_bridge_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WSEND = 3'd1;
  localparam logic [2:0] ST_WWAIT = 3'd2;
  localparam logic [2:0] ST_RSEND = 3'd3;
  localparam logic [2:0] ST_RWAIT = 3'd4;
  localparam logic [2:0] ST_RDONE = 3'd5;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int MODE_BIT       = DEF_DATA_WIDTH + DEF_ADDR_WIDTH;
  localparam int WDATA_LSB      = DEF_ADDR_WIDTH;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  // Callers pass zero-extended fields; the frame is LSB-aligned {mode, wdata, addr}.
  function automatic logic [63:0] pack_tx_frame(
    input logic        mode,
    input logic [31:0] wdata,
    input logic [31:0] addr,
    input int          dw = DEF_DATA_WIDTH,
    input int          aw = DEF_ADDR_WIDTH
  );
    logic [63:0] frame;
    frame = {63'd0, mode} << (dw + aw);
    frame = frame | ({32'd0, wdata} << aw);
    frame = frame | {32'd0, addr};
    return frame;
  endfunction

endpackage

// File: rtl/bridge_wfifo.sv
// rtl/bridge_wfifo.sv - posted-write FIFO holding {addr, wdata}; full/empty come from the level counter
module bridge_wfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_payload,
  output logic [WIDTH-1:0]         rd_payload,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full       = (level == FULL_LEVEL);
  assign empty      = (level == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_payload = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_payload;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/bus_bridge_uart_engine.sv
// rtl/bus_bridge_uart_engine.sv - slave-port to UART framer engine with posted writes and read retry
// Optional RX address echo check: BUS_BRIDGE_RD_ECHO_EN
module bus_bridge_uart_engine
  import bus_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int TX_FRAME_WIDTH = 32,
  parameter int RX_FRAME_WIDTH = 16,
  parameter int WFIFO_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRY      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           smemwen,
  input  logic                           smemren,
  input  logic [ADDR_WIDTH-1:0]          smemaddr,
  input  logic [DATA_WIDTH-1:0]          smemwdata,
  output logic [DATA_WIDTH-1:0]          smemrdata,
  output logic                           rvalid,
  output logic                           rerr,
  output logic                           sready,
  output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level,
  output logic [TX_FRAME_WIDTH-1:0]      u_din,
  output logic                           u_en,
  input  logic                           u_tx_busy,
  input  logic                           u_rx_ready,
  input  logic [RX_FRAME_WIDTH-1:0]      u_dout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

  logic [2:0]                       state;
  logic                             rd_pending;
  logic [ADDR_WIDTH-1:0]            rd_addr;
  logic [RW-1:0]                    retry;
  logic [TW-1:0]                    timer;
  logic                             seen_busy;
  logic                             tx_done;
  logic [DATA_WIDTH-1:0]            rd_data_q;
  logic                             rd_err_q;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             fifo_pop;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;
  logic                             rd_accept;
  logic                             rx_match;

  assign sready    = !rst && !fifo_full && !rd_pending;
  assign rd_accept = smemren && !rd_pending && !smemwen;
  assign fifo_pop  = (state == ST_WWAIT) && seen_busy && !u_tx_busy;
  assign rvalid    = (state == ST_RDONE);
  assign rerr      = rvalid && rd_err_q;
  assign smemrdata = rvalid ? rd_data_q : '0;

`ifdef BUS_BRIDGE_RD_ECHO_EN
  localparam int EW = RX_FRAME_WIDTH - DATA_WIDTH;
  assign rx_match = (u_dout[RX_FRAME_WIDTH-1:DATA_WIDTH] == EW'(rd_addr));
`else
  logic unused_rx_hi;
  assign unused_rx_hi = ^u_dout[RX_FRAME_WIDTH-1:DATA_WIDTH];
  assign rx_match     = 1'b1;
`endif

  // A pending read blocks new writes so nothing can slip in behind it.
  bridge_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH (ADDR_WIDTH + DATA_WIDTH)
  ) u_wfifo (
    .clk        (clk),
    .rst        (rst),
    .push       (smemwen && !rd_pending),
    .pop        (fifo_pop),
    .wr_payload ({smemaddr, smemwdata}),
    .rd_payload (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (wfifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_pending <= 1'b0;
      rd_addr    <= '0;
      retry      <= '0;
      timer      <= '0;
      seen_busy  <= 1'b0;
      tx_done    <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      u_din      <= '0;
      u_en       <= 1'b0;
    end else begin
      u_en <= 1'b0;
      if (rd_accept) begin
        rd_pending <= 1'b1;
        rd_addr    <= smemaddr;
      end
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_WSEND;
          else if (rd_pending) state <= ST_RSEND;
        end
        ST_WSEND: begin
          if (!u_tx_busy) begin
            u_din     <= TX_FRAME_WIDTH'(pack_tx_frame(MODE_WRITE,
                           32'(fifo_head[DATA_WIDTH-1:0]),
                           32'(fifo_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH]),
                           DATA_WIDTH, ADDR_WIDTH));
            u_en      <= 1'b1;
            seen_busy <= 1'b0;
            state     <= ST_WWAIT;
          end
        end
        ST_WWAIT: begin
          if (u_tx_busy) seen_busy <= 1'b1;
          else if (seen_busy) state <= ST_IDLE;
        end
        ST_RSEND: begin
          if (!u_tx_busy) begin
            u_din     <= TX_FRAME_WIDTH'(pack_tx_frame(MODE_READ, 32'd0, 32'(rd_addr),
                           DATA_WIDTH, ADDR_WIDTH));
            u_en      <= 1'b1;
            seen_busy <= 1'b0;
            tx_done   <= 1'b0;
            timer     <= '0;
            state     <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (u_tx_busy) seen_busy <= 1'b1;
          else if (seen_busy) tx_done <= 1'b1;
          if (u_rx_ready && rx_match) begin
            rd_data_q <= u_dout[DATA_WIDTH-1:0];
            rd_err_q  <= 1'b0;
            state     <= ST_RDONE;
          end else if (tx_done) begin
            if (timer == TIMEOUT_LAST) begin
              if (retry < RETRY_LIMIT) begin
                retry <= retry + 1'b1;
                state <= ST_RSEND;
              end else begin
                rd_data_q <= '1;
                rd_err_q  <= 1'b1;
                state     <= ST_RDONE;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        ST_RDONE: begin
          rd_pending <= 1'b0;
          retry      <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_bridge_uart_engine.sv
// tb/tb_bus_bridge_uart_engine.sv - scoreboard bench for bus_bridge_uart_engine
module tb_bus_bridge_uart_engine;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int TXW = 32;
  localparam int RXW = 16;
  localparam int DEPTH = 4;
  localparam int TMO = 16;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic smemwen = 1'b0;
  logic smemren = 1'b0;
  logic [AW-1:0] smemaddr = '0;
  logic [DW-1:0] smemwdata = '0;
  logic [DW-1:0] smemrdata;
  logic rvalid, rerr, sready, u_en;
  logic [$clog2(DEPTH):0] wfifo_level;
  logic [TXW-1:0] u_din;
  logic u_tx_busy = 1'b0;
  logic u_rx_ready;
  logic [RXW-1:0] u_dout;

  logic stray_rdy = 1'b0;
  logic resp_rdy = 1'b0;
  logic [RXW-1:0] resp_dout = '0;
  logic force_busy = 1'b0;

  assign u_rx_ready = stray_rdy | resp_rdy;
  assign u_dout     = stray_rdy ? 16'h0077 : resp_dout;

  int vectors = 0;
  int miscompares = 0;
  logic [TXW-1:0] exp_frames[$];
  logic [DW:0]    exp_reads[$];
  logic [RXW-1:0] rx_q[$];

  always #5 clk = ~clk;

  bus_bridge_uart_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TX_FRAME_WIDTH(TXW), .RX_FRAME_WIDTH(RXW),
    .WFIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .smemwen(smemwen), .smemren(smemren), .smemaddr(smemaddr),
    .smemwdata(smemwdata), .smemrdata(smemrdata), .rvalid(rvalid), .rerr(rerr),
    .sready(sready), .wfifo_level(wfifo_level), .u_din(u_din), .u_en(u_en),
    .u_tx_busy(u_tx_busy), .u_rx_ready(u_rx_ready), .u_dout(u_dout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    smemaddr = a; smemwdata = d; smemwen = 1'b1;
    cyc();
    smemwen = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int budget);
    int n;
    n = 0;
    smemaddr = a; smemren = 1'b1;
    do begin cyc(); n++; end while (!rvalid && n < budget);
    if (!rvalid) fail("read_timeout");
    smemren = 1'b0;
  endtask

  task automatic wait_frames(input int budget);
    int n;
    n = 0;
    while (exp_frames.size() > 0 && n < budget) begin cyc(); n++; end
    if (exp_frames.size() > 0) fail("frames_timeout");
  endtask

  task automatic wait_busy_low(input int budget);
    int n;
    n = 0;
    while (u_tx_busy && n < budget) begin cyc(); n++; end
    if (u_tx_busy) fail("busy_timeout");
  endtask

  // UART TX model: busy for 4 cycles after each start strobe, or held by force_busy.
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (u_en) busy_cnt = 4;
      else if (busy_cnt > 0) busy_cnt--;
      u_tx_busy = force_busy || (busy_cnt > 0);
    end
  end

  // RX responder: after a read frame finishes transmitting, replays the queued RX frames.
  initial begin
    logic [RXW-1:0] vals[$];
    int n;
    forever begin
      @(posedge clk); #2;
      if (u_en && !u_din[DW+AW] && rx_q.size() > 0) begin
        vals = rx_q;
        rx_q.delete();
        n = 0;
        while (u_tx_busy && n < 100) begin @(posedge clk); #2; n++; end
        foreach (vals[k]) begin
          repeat (3) @(posedge clk);
          #2;
          resp_dout = vals[k];
          resp_rdy  = 1'b1;
          @(posedge clk); #2;
          resp_rdy  = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every TX strobe and read completion against the scoreboard.
  initial begin
    logic prev_rv;
    logic [DW:0] e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (u_en) begin
        if (exp_frames.size() == 0) $display("FAIL unexpected_frame: got 0x%0h expected none", u_din);
        if (exp_frames.size() == 0) begin vectors++; miscompares++; end
        else check("tx_frame", 32'(u_din), 32'(exp_frames.pop_front()));
      end
      if (rvalid) begin
        if (prev_rv) fail("rvalid_width");
        if (exp_reads.size() == 0) fail("unexpected_rvalid");
        else begin
          e = exp_reads.pop_front();
          check("rd_data", 32'(smemrdata), 32'(e[DW-1:0]));
          check("rd_err", 32'(rerr), 32'(e[DW]));
        end
      end
      prev_rv = rvalid;
    end
  end

  initial begin
    repeat (3) cyc();
    check("rst_u_en", 32'(u_en), 0);
    check("rst_u_din", 32'(u_din), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rerr", 32'(rerr), 0);
    check("rst_rdata", 32'(smemrdata), 0);
    check("rst_level", 32'(wfifo_level), 0);
    check("rst_sready", 32'(sready), 0);
    rst = 1'b0;
    cyc();
    check("idle_sready", 32'(sready), 1);

    // Single posted write
    exp_frames.push_back(32'h0015A123);
    write(12'h123, 8'h5A);
    check("wlevel_1", 32'(wfifo_level), 1);
    wait_frames(50);
    wait_busy_low(50);
    cyc(); cyc();
    check("wlevel_0", 32'(wfifo_level), 0);

    // Fill FIFO while UART busy; fifth write ignored
    force_busy = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      smemaddr = AW'(12'h040 + i); smemwdata = DW'(8'hA0 + i); smemwen = 1'b1;
      cyc();
      if (i == 2) check("sready_at3", 32'(sready), 1);
      if (i == 3) check("sready_full", 32'(sready), 0);
    end
    smemwen = 1'b0;
    check("full_level", 32'(wfifo_level), 4);
    exp_frames.push_back(32'h001A0040);
    exp_frames.push_back(32'h001A1041);
    exp_frames.push_back(32'h001A2042);
    exp_frames.push_back(32'h001A3043);
    force_busy = 1'b0;
    wait_frames(300);
    wait_busy_low(50);
    cyc(); cyc();
    check("drain_level", 32'(wfifo_level), 0);

    // Read ordered behind two posted writes
    exp_frames.push_back(32'h00101201);
    exp_frames.push_back(32'h00102202);
    exp_frames.push_back(32'h00000010);
    rx_q.push_back(16'h00C3);
    exp_reads.push_back({1'b0, 8'hC3});
    write(12'h201, 8'h01);
    write(12'h202, 8'h02);
    do_read(12'h010, 400);

    // No response: three read frames then error
    repeat (3) exp_frames.push_back(32'h000002AB);
    exp_reads.push_back({1'b1, 8'hFF});
    do_read(12'h2AB, 1000);

    // Stray RX in IDLE, then simultaneous write and read
    cyc();
    stray_rdy = 1'b1;
    cyc();
    stray_rdy = 1'b0;
    cyc();
    exp_frames.push_back(32'h00111300);
    exp_frames.push_back(32'h00000300);
`ifdef BUS_BRIDGE_RD_ECHO_EN
    rx_q.push_back(16'h0044);
`else
    rx_q.push_back(16'h9944);
`endif
    exp_reads.push_back({1'b0, 8'h44});
    smemaddr = 12'h300; smemwdata = 8'h11; smemwen = 1'b1; smemren = 1'b1;
    cyc();
    smemwen = 1'b0;
    do_read(12'h300, 400);

`ifdef BUS_BRIDGE_RD_ECHO_EN
    exp_frames.push_back(32'h000000A5);
    rx_q.push_back(16'h1133);
    rx_q.push_back(16'hA533);
    exp_reads.push_back({1'b0, 8'h33});
    do_read(12'h0A5, 400);
`endif

    // Reset during WWAIT with three writes queued
    wait_busy_low(50);
    cyc();
    exp_frames.push_back(32'h00122400);
    for (int i = 0; i < 3; i++) begin
      smemaddr = AW'(12'h400 + i); smemwdata = DW'(8'h22 + 8'h11 * i); smemwen = 1'b1;
      cyc();
    end
    smemwen = 1'b0;
    wait_frames(50);
    cyc();
    check("pre_rst_level", 32'(wfifo_level), 3);
    rst = 1'b1;
    cyc();
    check("mid_rst_u_en", 32'(u_en), 0);
    check("mid_rst_u_din", 32'(u_din), 0);
    check("mid_rst_level", 32'(wfifo_level), 0);
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_sready", 32'(sready), 0);
    cyc();
    rst = 1'b0;
    repeat (60) cyc();
    check("post_rst_level", 32'(wfifo_level), 0);
    check("post_rst_sready", 32'(sready), 1);

    if (exp_frames.size() != 0) fail("frames_left");
    if (exp_reads.size() != 0) fail("reads_left");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
